axis_block_mean_centerer: RTL and testbench

Block-level mean-removal stage that consumes a raw AXIS sample stream, buffers one block of 2^ELEMENT_COUNT_LOG samples, computes the block mean, then replays the block as mean-centred residuals (sample − mean). It sits directly downstream of the sample generator / interval clamper and upstream of the residual coder. It produces the same mean as the pow2 averager, with the buffering and subtraction folded in, so no external FIFO is needed.

---
 rtl/axis_block_mean_centerer.sv | 122 ++++++++++++
 tb/tb_axis_block_mean_centerer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_block_mean_centerer.sv
// Buffers one block of 2^ELEMENT_COUNT_LOG samples, takes the floor mean, then
// replays the block as (sample - mean) residuals on a DATA_WIDTH+1 bit stream.
module axis_block_mean_centerer #(
    parameter int DATA_WIDTH        = 16,
    parameter int ELEMENT_COUNT_LOG = 8,
    parameter bit IS_SIGNED         = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH:0]   output_data,
    output logic                  output_last
);

    localparam int N  = 1 << ELEMENT_COUNT_LOG;
    localparam int AW = DATA_WIDTH + ELEMENT_COUNT_LOG;
    localparam logic [ELEMENT_COUNT_LOG-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {StFill, StMean, StDrain} state_e;

    state_e                       r_state;
    state_e                       w_state_next;
    logic                         r_in_ready;
    logic [ELEMENT_COUNT_LOG-1:0] r_wr_cnt;
    logic [ELEMENT_COUNT_LOG-1:0] r_rd_cnt;
    logic [AW-1:0]                r_acc;
    logic [DATA_WIDTH-1:0]        r_mean;
    logic [DATA_WIDTH-1:0]        r_rd_data;
    logic [DATA_WIDTH-1:0]        r_mem [N];

    logic                         w_in_hs;
    logic                         w_out_hs;
    logic                         w_rd_en;
    logic [ELEMENT_COUNT_LOG-1:0] w_rd_addr;
    logic                         w_in_sign;
    logic                         w_rd_sign;
    logic                         w_mean_sign;
    logic [AW-1:0]                w_in_ext;
    logic [DATA_WIDTH:0]          w_residual;

    assign w_in_hs     = r_in_ready && input_valid;
    assign w_out_hs    = output_valid && output_ready;

    assign w_in_sign   = IS_SIGNED & input_data[DATA_WIDTH-1];
    assign w_rd_sign   = IS_SIGNED & r_rd_data[DATA_WIDTH-1];
    assign w_mean_sign = IS_SIGNED & r_mean[DATA_WIDTH-1];
    assign w_in_ext    = {{ELEMENT_COUNT_LOG{w_in_sign}}, input_data};
    // Both operands fit DATA_WIDTH bits, so the DATA_WIDTH+1 bit difference is exact.
    assign w_residual  = {w_rd_sign, r_rd_data} - {w_mean_sign, r_mean};

    assign input_ready  = r_in_ready;
    assign output_valid = (r_state == StDrain);
    assign output_last  = output_valid && (r_rd_cnt == LAST_IDX);
    assign output_data  = output_valid ? w_residual : '0;

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_rd_addr    = r_rd_cnt + 1'b1;
        unique case (r_state)
            StFill: begin
                if (w_in_hs && (r_wr_cnt == LAST_IDX)) begin
                    w_state_next = StMean;
                end
            end
            StMean: begin
                w_state_next = StDrain;
                w_rd_en      = 1'b1;
                w_rd_addr    = '0;
            end
            StDrain: begin
                // Prefetch the next address on each handshake; a stall freezes the read.
                w_rd_en = output_ready;
                if (output_ready && (r_rd_cnt == LAST_IDX)) begin
                    w_state_next = StFill;
                end
            end
            default: w_state_next = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_mem[r_wr_cnt] <= input_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StFill;
            r_in_ready <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_acc      <= '0;
            r_mean     <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == StFill);
            if (w_in_hs) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                r_acc    <= r_acc + w_in_ext;
            end
            if (r_state == StMean) begin
                // Top DATA_WIDTH bits are the floor of sum/N for both signednesses.
                r_mean <= r_acc[AW-1:ELEMENT_COUNT_LOG];
                r_acc  <= '0;
            end
            if (w_out_hs) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_axis_block_mean_centerer.sv
// Directed bench: three instances (unsigned N=4, signed N=4, unsigned N=256),
// inputs driven and outputs sampled on the falling clock edge.
module tb_axis_block_mean_centerer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] in_data   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [16:0] out_data  [3];
    logic        out_last  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_block_mean_centerer #(
        .DATA_WIDTH(16), .ELEMENT_COUNT_LOG(2), .IS_SIGNED(1'b0)
    ) u_uns (
        .clk(clk), .rst(rst),
        .input_valid(in_valid[0]), .input_ready(in_ready[0]), .input_data(in_data[0]),
        .output_valid(out_valid[0]), .output_ready(out_ready[0]),
        .output_data(out_data[0]), .output_last(out_last[0])
    );

    axis_block_mean_centerer #(
        .DATA_WIDTH(16), .ELEMENT_COUNT_LOG(2), .IS_SIGNED(1'b1)
    ) u_sgn (
        .clk(clk), .rst(rst),
        .input_valid(in_valid[1]), .input_ready(in_ready[1]), .input_data(in_data[1]),
        .output_valid(out_valid[1]), .output_ready(out_ready[1]),
        .output_data(out_data[1]), .output_last(out_last[1])
    );

    axis_block_mean_centerer #(
        .DATA_WIDTH(16), .ELEMENT_COUNT_LOG(8), .IS_SIGNED(1'b0)
    ) u_big (
        .clk(clk), .rst(rst),
        .input_valid(in_valid[2]), .input_ready(in_ready[2]), .input_data(in_data[2]),
        .output_valid(out_valid[2]), .output_ready(out_ready[2]),
        .output_data(out_data[2]), .output_last(out_last[2])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int res(input int k);
        return int'($signed(out_data[k]));
    endfunction

    task automatic feed4(input int k, input int a, input int b, input int c, input int e);
        int d [4];
        int n;
        d = '{a, b, c, e};
        for (int i = 0; i < 4; i++) begin
            in_data[k]  = 16'(d[i]);
            in_valid[k] = 1'b1;
            n = 0;
            while (!in_ready[k] && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("feed%0d_ready_timeout", k), int'(n < 50), 1);
            @(negedge clk);
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic drain4(input int k, input int a, input int b, input int c, input int e,
                          input int n_take, input string tag);
        int x [4];
        int n;
        x = '{a, b, c, e};
        out_ready[k] = 1'b1;
        for (int i = 0; i < n_take; i++) begin
            n = 0;
            while (!out_valid[k] && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("%s_valid_timeout", tag), int'(n < 50), 1);
            chk($sformatf("%s_data%0d", tag, i), res(k), x[i]);
            chk($sformatf("%s_last%0d", tag, i), int'(out_last[k]), int'(i == 3));
            @(negedge clk);
        end
        if (n_take == 4) begin
            chk($sformatf("%s_ready_after_last", tag), int'(in_ready[k]), 1);
            chk($sformatf("%s_idle_after_last", tag), int'(out_valid[k]), 0);
        end
    endtask

    initial begin
        int   iidx;
        int   oidx;
        int   last_cyc [$];
        bit   prev_last_hs;
        int   b2b_exp [4];
        int   ramp [768];
        int   exp_big [768];
        bit   pat [6];
        bit   prev_stall;
        int   prev_data;
        int   prev_last;
        int   cyc;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready%0d", k), int'(in_ready[k]), 0);
            chk($sformatf("rst_out_valid%0d", k), int'(out_valid[k]), 0);
            chk($sformatf("rst_out_last%0d", k), int'(out_last[k]), 0);
            chk($sformatf("rst_out_data%0d", k), int'(out_data[k]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_rst_ready%0d", k), int'(in_ready[k]), 1);
        end

        // Basic block with latency: MEAN cycle, then first residual.
        feed4(0, 10, 20, 30, 40);
        chk("basic_mean_valid", int'(out_valid[0]), 0);
        chk("basic_mean_ready", int'(in_ready[0]), 0);
        @(negedge clk);
        chk("basic_latency_valid", int'(out_valid[0]), 1);
        drain4(0, -15, -5, 5, 15, 4, "basic");

        feed4(0, 1, 2, 2, 2);
        drain4(0, 0, 1, 1, 1, 4, "floor_uns");

        feed4(1, -1, -2, -2, -2);
        drain4(1, 1, 0, 0, 0, 4, "floor_sgn");

        feed4(0, 65535, 65535, 65535, 65535);
        drain4(0, 0, 0, 0, 0, 4, "ext_max");

        feed4(0, 0, 0, 0, 65535);
        drain4(0, -16383, -16383, -16383, 49152, 4, "ext_skew");

        // Reset after the second residual of a block.
        feed4(0, 10, 20, 30, 40);
        drain4(0, -15, -5, 5, 15, 2, "pre_rst");
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", int'(out_valid[0]), 0);
        chk("mid_rst_ready", int'(in_ready[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_after", int'(in_ready[0]), 1);
        chk("mid_rst_no_output", int'(out_valid[0]), 0);
        feed4(0, 4, 4, 4, 8);
        drain4(0, -1, -1, -1, 3, 4, "post_rst");

        // Back-to-back: three blocks with both sides always ready.
        b2b_exp      = '{-15, -5, 5, 15};
        iidx         = 0;
        oidx         = 0;
        prev_last_hs = 1'b0;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (prev_last_hs) chk("b2b_ready_after_last", int'(in_ready[0]), 1);
            prev_last_hs = out_valid[0] && out_last[0];
            if (out_valid[0]) begin
                chk($sformatf("b2b_data%0d", oidx), res(0), b2b_exp[oidx % 4]);
                if (out_last[0]) last_cyc.push_back(c);
                oidx++;
            end
            in_valid[0] = (iidx < 12);
            in_data[0]  = 16'(10 * (iidx % 4 + 1));
            if (in_valid[0] && in_ready[0]) iidx++;
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        chk("b2b_out_count", oidx, 12);
        chk("b2b_last_count", last_cyc.size(), 3);
        if (last_cyc.size() == 3) begin
            chk("b2b_period_1", last_cyc[1] - last_cyc[0], 9);
            chk("b2b_period_2", last_cyc[2] - last_cyc[1], 9);
        end

        // Backpressure: N=256 ramp blocks, random input gaps, patterned output_ready.
        for (int b = 0; b < 3; b++) begin
            int sum;
            sum = 0;
            for (int i = 0; i < 256; i++) begin
                ramp[b*256 + i] = b * 3000 + i * 37 + (i % 3) * 11;
                sum += ramp[b*256 + i];
            end
            for (int i = 0; i < 256; i++) exp_big[b*256 + i] = ramp[b*256 + i] - sum / 256;
        end
        pat        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        iidx       = 0;
        oidx       = 0;
        prev_stall = 1'b0;
        prev_data  = 0;
        prev_last  = 0;
        cyc        = 0;
        while (oidx < 768 && cyc < 8000) begin
            out_ready[2] = pat[cyc % 6];
            if (prev_stall) begin
                chk("bp_stall_valid", int'(out_valid[2]), 1);
                chk("bp_stall_data", res(2), prev_data);
                chk("bp_stall_last", int'(out_last[2]), prev_last);
            end
            if (out_valid[2]) chk("bp_no_input_in_drain", int'(in_ready[2]), 0);
            if (out_valid[2] && out_ready[2]) begin
                chk($sformatf("bp_data%0d", oidx), res(2), exp_big[oidx]);
                chk($sformatf("bp_last%0d", oidx), int'(out_last[2]), int'(oidx % 256 == 255));
                oidx++;
            end
            prev_stall = out_valid[2] && !out_ready[2];
            prev_data  = res(2);
            prev_last  = int'(out_last[2]);
            in_valid[2] = (iidx < 768) && ($urandom_range(0, 3) != 0);
            in_data[2]  = (iidx < 768) ? 16'(ramp[iidx]) : 16'hDEAD;
            if (in_valid[2] && in_ready[2]) iidx++;
            @(negedge clk);
            cyc++;
        end
        in_valid[2] = 1'b0;
        chk("bp_all_outputs", oidx, 768);
        chk("bp_all_inputs", iidx, 768);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
